// File: rtl/ex_pkg.sv
// Shared types for the burst transmitter: element and sum formats plus the TX FSM states.
package ex_pkg;
    typedef logic [15:0] bf16_t;
    typedef logic [31:0] fp32_t;
    typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_e;
endpackage

// File: rtl/ex_sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous flush; DEPTH must be a power of two >= 2.
module ex_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/ex_burst_tx.sv
// Buffers bf16 vectors and emits each as one contiguous data_en burst; tags returned fp32 sums
// with their burst length. Define EX_BURST_TX_STATS_EN to add burst/element statistic counters.
module ex_burst_tx
    import ex_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_OUT = 4,
    parameter int LEN_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  bf16_t            in_data,
    input  logic             in_last,
    output logic             data_en_o,
    output bf16_t            data_o,
    input  logic             sum_en_i,
    input  fp32_t            sum_i,
    output logic             res_valid,
    output fp32_t            res_data,
    output logic [LEN_W-1:0] res_len,
    output logic             busy,
    output logic             err_o
`ifdef EX_BURST_TX_STATS_EN
    ,
    output logic [31:0]      stat_bursts,
    output logic [31:0]      stat_elems
`endif
);
    localparam int VEC_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    tx_state_e        state_q, state_d;
    logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [LEN_W-1:0] len_q, cur_len, lq_head, res_len_q, res_len_d;
    logic             data_en_q, res_valid_q, err_q;
    bf16_t            data_q, head_data;
    fp32_t            res_data_q;
    logic [16:0]      buf_rdata;
    logic             head_last, buf_full, buf_empty, lq_full, lq_empty;
    logic             push, pop, last_pop, overflow, start_ok, start, start_go;
    logic             ret, sum_err, lq_push, lq_pop;

    assign head_data = buf_rdata[16:1];
    assign head_last = buf_rdata[0];
    assign in_ready  = !buf_full;
    assign push      = enable && in_valid && !buf_full;
    assign pop       = enable && (state_q == SEND);
    assign last_pop  = pop && head_last;
    // A full buffer without a complete vector can never drain: drop it.
    assign overflow  = enable && buf_full && (vec_cnt_q == '0);
    assign start_ok  = (vec_cnt_q != '0) && (out_cnt_q < CNT_W'(MAX_OUT));
    assign start_go  = enable && start;
    assign ret       = enable && sum_en_i && (out_cnt_q != '0);
    assign sum_err   = enable && sum_en_i && (out_cnt_q == '0);
    assign cur_len   = len_q + LEN_W'(1);
    // A sum landing on the same edge the length is queued bypasses the length queue.
    assign lq_push   = last_pop && !lq_full && !(ret && lq_empty);
    assign lq_pop    = ret && !lq_empty;
    assign res_len_d = lq_empty ? cur_len : lq_head;

    ex_sync_fifo #(.WIDTH(17), .DEPTH(DEPTH)) u_buf (
        .clk(clk), .rst(rst), .flush_i(overflow), .push_i(push), .pop_i(pop),
        .wdata_i({in_data, in_last}), .rdata_o(buf_rdata), .full_o(buf_full), .empty_o(buf_empty)
    );

    ex_sync_fifo #(.WIDTH(LEN_W), .DEPTH(MAX_OUT)) u_lenq (
        .clk(clk), .rst(rst), .flush_i(1'b0), .push_i(lq_push), .pop_i(lq_pop),
        .wdata_i(cur_len), .rdata_o(lq_head), .full_o(lq_full), .empty_o(lq_empty)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (start_ok) begin
                state_d = SEND;
                start   = 1'b1;
            end
            SEND: if (head_last) state_d = GAP;
            GAP: begin
                state_d = start_ok ? SEND : IDLE;
                start   = start_ok;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         state_q <= IDLE;
        else if (enable) state_q <= state_d;
    end

    always_comb begin
        vec_cnt_d = vec_cnt_q;
        out_cnt_d = out_cnt_q;
        if ((push && in_last) && !last_pop)      vec_cnt_d = vec_cnt_q + VEC_W'(1);
        else if (!(push && in_last) && last_pop) vec_cnt_d = vec_cnt_q - VEC_W'(1);
        if (start_go && !ret)      out_cnt_d = out_cnt_q + CNT_W'(1);
        else if (!start_go && ret) out_cnt_d = out_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt_q   <= '0;
            out_cnt_q   <= '0;
            len_q       <= '0;
            data_en_q   <= 1'b0;
            data_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_len_q   <= '0;
            err_q       <= 1'b0;
        end else if (enable) begin
            vec_cnt_q   <= vec_cnt_d;
            out_cnt_q   <= out_cnt_d;
            len_q       <= last_pop ? '0 : (pop ? cur_len : len_q);
            data_en_q   <= pop;
            if (pop) data_q <= head_data;
            res_valid_q <= ret;
            if (ret) begin
                res_data_q <= sum_i;
                res_len_q  <= res_len_d;
            end
            err_q       <= err_q | sum_err | overflow;
        end
    end

    assign data_en_o = data_en_q;
    assign data_o    = data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_len   = res_len_q;
    assign err_o     = err_q;
    assign busy      = !buf_empty || (state_q != IDLE) || (out_cnt_q != '0);

`ifdef EX_BURST_TX_STATS_EN
    logic [31:0] stat_bursts_q, stat_elems_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bursts_q <= '0;
            stat_elems_q  <= '0;
        end else if (enable) begin
            if (start_go) stat_bursts_q <= stat_bursts_q + 32'd1;
            if (pop)      stat_elems_q  <= stat_elems_q + 32'd1;
        end
    end

    assign stat_bursts = stat_bursts_q;
    assign stat_elems  = stat_elems_q;
`endif
endmodule

// File: tb/tb_ex_burst_tx.sv
// Scoreboard bench for ex_burst_tx: directed scenarios plus randomized vectors and sum returns.
module tb_ex_burst_tx;
    localparam int DEPTH   = 16;
    localparam int MAX_OUT = 4;
    localparam int LEN_W   = $clog2(DEPTH) + 1;

    logic             clk = 1'b0, rst = 1'b1, enable = 1'b1;
    logic             in_valid = 1'b0, in_last = 1'b0, sum_en_i = 1'b0;
    logic [15:0]      in_data = '0;
    logic [31:0]      sum_i = '0;
    logic             in_ready, data_en_o, res_valid, busy, err_o;
    logic [15:0]      data_o;
    logic [31:0]      res_data;
    logic [LEN_W-1:0] res_len;
`ifdef EX_BURST_TX_STATS_EN
    logic [31:0]      stat_bursts, stat_elems;
`endif

    always #5 clk = ~clk;

    ex_burst_tx #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .data_en_o(data_en_o), .data_o(data_o),
        .sum_en_i(sum_en_i), .sum_i(sum_i),
        .res_valid(res_valid), .res_data(res_data), .res_len(res_len),
        .busy(busy), .err_o(err_o)
`ifdef EX_BURST_TX_STATS_EN
        , .stat_bursts(stat_bursts), .stat_elems(stat_elems)
`endif
    );

    int errors = 0, checks = 0;
    logic [16:0] exp_beats[$];
    logic [31:0] exp_sum[$];
    int          exp_len[$];
    int          burst_lens[$];
    int          cur_len = 0;
    bit          expect_gap = 0;
    logic        en_s = 1'b0, rst_s = 1'b1;
    logic [16:0] mon_e;
    logic [4:0]  pat;
    logic [15:0] vec5 [6];
    int          vlen, nsum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        en_s  <= enable;
        rst_s <= rst;
    end

    // Monitor: outputs only advance on enabled edges, so sample once per such edge.
    always @(negedge clk) begin
        if (rst_s) begin
            exp_beats.delete();
            exp_sum.delete();
            exp_len.delete();
            burst_lens.delete();
            cur_len    = 0;
            expect_gap = 0;
        end else if (en_s) begin
            if (expect_gap) begin
                chk("gap_low", 32'(data_en_o), 32'd0);
                expect_gap = 0;
            end else if (cur_len > 0) begin
                chk("burst_contig", 32'(data_en_o), 32'd1);
            end
            if (data_en_o) begin
                if (exp_beats.size() == 0) chk("beat_unexpected", 32'(data_en_o), 32'd0);
                else begin
                    mon_e = exp_beats.pop_front();
                    chk("beat_data", 32'(data_o), 32'(mon_e[16:1]));
                    cur_len++;
                    if (mon_e[0]) begin
                        burst_lens.push_back(cur_len);
                        cur_len    = 0;
                        expect_gap = 1;
                    end
                end
            end
            if (res_valid) begin
                if (exp_sum.size() == 0) chk("res_unexpected", 32'(res_valid), 32'd0);
                else begin
                    chk("res_data", res_data, exp_sum.pop_front());
                    chk("res_len", 32'(res_len), 32'(exp_len.pop_front()));
                end
            end
        end
    end

    task automatic push_elem(input logic [15:0] d, input logic last, input bit rec);
        int guard = 0;
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!ok && guard < 300) begin
            @(negedge clk);
            ok = in_ready && enable;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("push_timeout", 32'(ok), 32'd1);
        else if (rec) exp_beats.push_back({d, last});
    endtask

    // Expected tag is the length of the oldest completed burst still awaiting its sum.
    task automatic do_sum(input logic [31:0] v);
        sum_en_i = 1'b1;
        sum_i    = v;
        if (burst_lens.size() > 0) begin
            exp_sum.push_back(v);
            exp_len.push_back(burst_lens.pop_front());
        end
        @(posedge clk);
        #1;
        sum_en_i = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_beats.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("drain", 32'(exp_beats.size()), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res();
        int g = 0;
        while (exp_sum.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("results_returned", 32'(exp_sum.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beat();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!data_en_o && g < 100);
        chk("beat_seen", 32'(data_en_o), 32'd1);
    endtask

    task automatic return_all();
        while (burst_lens.size() > 0) do_sum($urandom);
        wait_res();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_data_en", 32'(data_en_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_len", 32'(res_len), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Sum with nothing outstanding: flagged, no result.
        @(posedge clk); #1;
        do_sum(32'hDEAD_BEEF);
        @(negedge clk);
        chk("err_no_outstanding", 32'(err_o), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_rst", 32'(err_o), 32'd0);
        @(posedge clk); #1;

        // Three-element vector, latency and tagged return.
        push_elem(16'h3F80, 1'b0, 1);
        push_elem(16'h4000, 1'b0, 1);
        push_elem(16'h4040, 1'b1, 1);
        @(negedge clk);
        @(negedge clk);
        chk("lat_before", 32'(data_en_o), 32'd0);
        @(negedge clk);
        chk("lat_first_beat", 32'(data_en_o), 32'd1);
        chk("lat_first_data", 32'(data_o), 32'h3F80);
        wait_drain();
        do_sum(32'h40C0_0000);
        wait_res();

        // Two queued vectors: high, high, low, high, low.
        push_elem(16'h1111, 1'b0, 1);
        push_elem(16'h2222, 1'b1, 1);
        push_elem(16'h3333, 1'b1, 1);
        @(negedge clk);
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pat = {pat[3:0], data_en_o};
        end
        chk("two_vec_pattern", 32'(pat), 32'h1A);
        wait_drain();
        return_all();

        // Five vectors with no returns: only MAX_OUT bursts go out.
        for (int i = 0; i < 5; i++) push_elem(16'h5000 + 16'(i), 1'b1, 1);
        repeat (40) @(negedge clk);
        chk("fifth_held", 32'(exp_beats.size()), 32'd1);
        chk("bursts_outstanding", 32'(burst_lens.size()), 32'(MAX_OUT));
        chk("busy_held", 32'(busy), 32'd1);
        @(posedge clk); #1;
        do_sum(32'h3F80_0000);
        wait_drain();
        return_all();

        // Vector longer than the buffer: flushed and flagged.
        for (int i = 0; i < DEPTH; i++) push_elem(16'hA000 + 16'(i), 1'b0, 0);
        @(negedge clk);
        chk("ovf_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ovf_ready_again", 32'(in_ready), 32'd1);
        chk("ovf_err", 32'(err_o), 32'd1);
        @(posedge clk); #1;
        push_elem(16'hBEEF, 1'b1, 1);
        wait_drain();
        return_all();

        // Enable low for three cycles mid-burst.
        for (int i = 0; i < 6; i++) vec5[i] = 16'hC000 + 16'(i * 3);
        for (int i = 0; i < 6; i++) push_elem(vec5[i], i == 5, 1);
        wait_beat();
        @(posedge clk); #1 enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frozen_en", 32'(data_en_o), 32'd1);
            chk("frozen_data", 32'(data_o), 32'(vec5[1]));
        end
        @(posedge clk); #1 enable = 1'b1;
        wait_drain();
        return_all();
        chk("err_sticky", 32'(err_o), 32'd1);

        // Reset mid-burst.
        for (int i = 0; i < 4; i++) push_elem(16'hD000 + 16'(i), i == 3, 1);
        wait_beat();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_data_en", 32'(data_en_o), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_err", 32'(err_o), 32'd0);
        @(posedge clk); #1;

        // Randomized vectors with interleaved sum returns.
        for (int v = 0; v < 24; v++) begin
            vlen = $urandom_range(1, 6);
            for (int i = 0; i < vlen; i++) begin
                push_elem(16'($urandom), i == vlen - 1, 1);
                if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
            nsum = $urandom_range(0, burst_lens.size());
            repeat (nsum) do_sum($urandom);
            if (v % 3 == 2) begin
                wait_drain();
                return_all();
            end
        end
        wait_drain();
        return_all();
        chk("final_err", 32'(err_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_burst_tx.md
# ex_burst_tx

Burst transmitter feeding the bf16 accumulate unit. It buffers bf16 elements arriving on a valid/ready stream, holds each vector until its last element is in, then emits the vector as one unbroken `data_en` burst with at least one idle cycle between bursts. The accumulator uses the burst edges to start and finish a sum. The block also takes back each fp32 sum, tags it with the length of its burst, and tracks outstanding bursts.

## Interface
- `DEPTH`, 16: element buffer entries (power of two, ≥2).
- `MAX_OUT`, 4: maximum bursts sent whose sum has not yet returned (power of two).
- `LEN_W`, `$clog2(DEPTH)+1`: burst-length field width.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: global advance; when low, all state and outputs hold.
- `in_valid` in 1: upstream element valid.
- `in_ready` out 1: element accepted when `in_valid & in_ready & enable`.
- `in_data` in 16: bf16 element.
- `in_last` in 1: element closes its vector.
- `data_en_o` out 1: burst framing toward accumulator (registered).
- `data_o` out 16: bf16 element toward accumulator (registered).
- `sum_en_i` in 1: one-cycle pulse, returned sum valid.
- `sum_i` in 32: fp32 sum.
- `res_valid` out 1: one-cycle pulse, tagged result.
- `res_data` out 32: fp32 sum.
- `res_len` out LEN_W: element count of the burst that produced `res_data`.
- `busy` out 1: buffer non-empty, FSM not IDLE, or sums outstanding.
- `err_o` out 1: sticky error flag, cleared only by `rst`.

## Operation
- Element buffer: FIFO of {in_data, in_last}. `in_ready = !full`. Push and pop in the same cycle are allowed.
- `vec_cnt` counts complete vectors in the buffer. It increments on push of `in_last` and decrements on pop of `in_last`. Both in one cycle leave it unchanged.
- `out_cnt` (0..MAX_OUT) counts bursts started minus sums returned.
- FSM:
  - IDLE → SEND when `vec_cnt>0 && out_cnt<MAX_OUT`.
  - SEND: pop one element per cycle; `data_en_o=1`, `data_o`=element. When the popped element has last=1 → GAP.
  - GAP: `data_en_o=0` for one cycle → SEND if the IDLE start condition holds, else IDLE.
  - Bursts are never split: SEND starts only when the full vector is buffered.
- Burst start (IDLE/GAP → SEND): `out_cnt++` and the vector length is pushed into the length queue (depth MAX_OUT). The length is counted during SEND and pushed at burst end, before any sum can return.
- Sum return: when `sum_en_i` and `out_cnt>0`, the next cycle drives `res_valid=1`, `res_data=sum_i`, `res_len`=popped queue head; `out_cnt--`.
  - `sum_en_i` with `out_cnt==0`: ignored, `err_o←1`.
  - Simultaneous start and return: `out_cnt` is unchanged.
- Overflow: buffer full with `vec_cnt==0` (vector longer than DEPTH) → buffer flushed, `err_o←1`, `in_ready` high again the next cycle.
- Single-element vectors are legal: a one-cycle burst.

## Timing
- Reset values: `data_en_o=0`, `data_o=0`, `res_valid=0`, `res_data=0`, `res_len=0`, `err_o=0`, `busy=0`, `in_ready=1`. FSM=IDLE; counters and queues empty.
- Latency: with the FSM idle and `out_cnt<MAX_OUT`, the first element appears on `data_o` with `data_en_o=1` two enabled cycles after the `in_last` handshake.
- Throughput: N-element burst = N cycles high, then exactly 1 low cycle before the next burst.
- Return: `res_valid` is asserted 1 cycle after `sum_en_i`.
- `enable` low mid-burst: `data_en_o`/`data_o` hold and the burst stays contiguous in enabled cycles.
- `rst` mid-burst: `data_en_o` is low the next cycle and everything is cleared. The accumulator shares `rst`, so no partial sum is expected.

## Configuration
- `EX_BURST_TX_STATS_EN` defined: adds outputs `stat_bursts` (32) and `stat_elems` (32).
  - Incremented per burst start and per element sent; wrap at 2^32; cleared by `rst`; frozen when `enable` is low.
- Undefined: these ports and counters do not exist.

## Structure
- Shared package `ex_pkg`: `bf16_t` (16-bit), `fp32_t` (32-bit), FSM state enum `tx_state_e` {IDLE, SEND, GAP}.
- Sub-module `ex_sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/flush), instantiated twice: the element buffer and the length queue.

## Test plan
- Vector {0x3F80, 0x4000, 0x4040} with last on the third element → `data_en_o` high 3 cycles carrying 0x3F80, 0x4000, 0x4040, first beat 2 cycles after the last handshake. Then `sum_en_i` with 0x40C00000 → `res_valid` with `res_data=0x40C00000`, `res_len=3`.
- Two queued vectors of 2 and 1 elements → pattern high, high, low, high, low. `out_cnt` reaches 2.
- MAX_OUT=4: five vectors with no sums returned → four bursts sent, fifth held. One `sum_en_i` → fifth burst starts after the GAP/IDLE rules.
- DEPTH=16: 16 elements without `in_last` → flush, `err_o=1`, `in_ready=1` next cycle. A following 1-element vector is sent normally.
- `sum_en_i` at reset with nothing outstanding → `err_o=1`, no `res_valid`. `enable` low for 3 cycles mid-burst → outputs frozen, burst contiguous. `rst` mid-burst → `data_en_o=0` next cycle, `busy=0`.
